byte_unstrip: RTL

//  Receive-side counterpart of the 4-lane byte striper. Accepts one 4-lane symbol word per

---
 rtl/byte_strip_pkg.sv | 44 ++++
 rtl/byte_unstrip_if.sv | 23 ++
 rtl/lane_word_fifo.sv | 59 +++++
 rtl/byte_unstrip.sv | 118 +++++++++++
 4 files changed

// File: rtl/byte_strip_pkg.sv
// Shared definitions for the 4-lane byte striper and unstriper.
package byte_strip_pkg;

   localparam int unsigned LANES = 4;
   localparam int unsigned SYM_W = 8;

   // Framing / control symbol codes
   localparam logic [SYM_W-1:0] STP = 8'hFB;
   localparam logic [SYM_W-1:0] SDP = 8'h5C;
   localparam logic [SYM_W-1:0] END = 8'hFD;
   localparam logic [SYM_W-1:0] EDB = 8'hFE;
   localparam logic [SYM_W-1:0] COM = 8'hBC;
   localparam logic [SYM_W-1:0] SKP = 8'h1C;
   localparam logic [SYM_W-1:0] IDL = 8'h7C;

   // Framing error causes, lowest value has priority
   localparam logic [2:0] ERR_NONE       = 3'd0;
   localparam logic [2:0] ERR_START_LANE = 3'd1;
   localparam logic [2:0] ERR_END_LANE   = 3'd2;
   localparam logic [2:0] ERR_NESTED     = 3'd3;
   localparam logic [2:0] ERR_DATA_IDLE  = 3'd4;
   localparam logic [2:0] ERR_RESERVED   = 3'd5;

   typedef enum logic {ST_IDLE = 1'b0, ST_PKT = 1'b1} frame_state_t;

   // One striped word: sym[0]/dk[0] is lane0
   typedef struct packed {
      logic [LANES-1:0][SYM_W-1:0] sym;
      logic [LANES-1:0]            dk;
   } lane_word_t;

   function automatic logic is_start(input logic [SYM_W-1:0] s, input logic dk);
      return !dk && (s == STP || s == SDP);
   endfunction

   function automatic logic is_end(input logic [SYM_W-1:0] s, input logic dk);
      return !dk && (s == END || s == EDB);
   endfunction

   function automatic logic is_frame_code(input logic [SYM_W-1:0] s);
      return (s == STP) || (s == SDP) || (s == END) || (s == EDB);
   endfunction

endpackage

// File: rtl/byte_unstrip_if.sv
// Lane-word input and serial byte output bundle of the unstriper.
interface byte_unstrip_if #(parameter int unsigned BITS = 8) ();
   logic [BITS-1:0] LANE0, LANE1, LANE2, LANE3;
   logic            DK_0, DK_1, DK_2, DK_3;
   logic            VALID_IN;
   logic            READY_IN;
   logic [BITS-1:0] D;
   logic            DK;
   logic            VALID_OUT;
   logic            IN_PKT;
   logic            ERR;
   logic [2:0]      ERR_CODE;

   modport master (
      output LANE0, LANE1, LANE2, LANE3, DK_0, DK_1, DK_2, DK_3, VALID_IN,
      input  READY_IN, D, DK, VALID_OUT, IN_PKT, ERR, ERR_CODE
   );

   modport slave (
      input  LANE0, LANE1, LANE2, LANE3, DK_0, DK_1, DK_2, DK_3, VALID_IN,
      output READY_IN, D, DK, VALID_OUT, IN_PKT, ERR, ERR_CODE
   );
endinterface

// File: rtl/lane_word_fifo.sv
// Small register FIFO holding striped lane words awaiting serialisation.
module lane_word_fifo #(
   parameter int unsigned W     = 36,
   parameter int unsigned DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_push,
   input  logic [W-1:0]             i_data,
   input  logic                     i_pop,
   output logic [W-1:0]             o_head_c,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_empty_c
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic [W-1:0]  r_mem [DEPTH];
   logic [PW-1:0] r_wr, r_rd;
   logic [CW-1:0] r_count;
   logic          w_full, w_push, w_pop;

   assign w_full    = (r_count == CW'(DEPTH));
   assign o_empty_c = (r_count == '0);
   assign w_push    = i_push && !w_full;
   assign w_pop     = i_pop && !o_empty_c;
   assign o_head_c  = r_mem[r_rd];
   assign o_count   = r_count;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Pointers and occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wr <= ptr_inc(r_wr);
         if (w_pop)  r_rd <= ptr_inc(r_rd);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      end else if (w_push) begin
         r_mem[r_wr] <= i_data;
      end
   end
endmodule

// File: rtl/byte_unstrip.sv
// Re-serialises 4-lane symbol words into a byte stream and checks packet framing.
module byte_unstrip
   import byte_strip_pkg::*;
#(
   parameter int unsigned BITS  = 8,
   parameter int unsigned DEPTH = 2
) (
   input  logic          CLK,
   input  logic          RESET_L,
   byte_unstrip_if.slave bus
);
   localparam int unsigned W  = LANES * BITS + LANES;
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   lane_word_t     w_in, w_head;
   logic [W-1:0]   w_head_raw;
   logic [CW-1:0]  w_count;
   logic           w_empty, w_push, w_pop;
   logic [1:0]     r_lane;
   logic [BITS-1:0] r_d;
   logic           r_dk, r_valid;
   frame_state_t   r_state, w_state_nxt, w_mid;
   logic [5:1]     w_hit;
   logic [2:0]     w_code;
   logic           r_err;
   logic [2:0]     r_err_code;

   assign w_in = {bus.LANE3, bus.LANE2, bus.LANE1, bus.LANE0,
                  bus.DK_3, bus.DK_2, bus.DK_1, bus.DK_0};

   assign bus.READY_IN = (w_count < CW'(DEPTH));
   assign w_push       = bus.VALID_IN && bus.READY_IN;
   assign w_pop        = !w_empty && (r_lane == 2'd3);
   assign w_head       = lane_word_t'(w_head_raw);

   lane_word_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
      .clk       (CLK),
      .rst_n     (RESET_L),
      .i_push    (w_push),
      .i_data    (w_in),
      .i_pop     (w_pop),
      .o_head_c  (w_head_raw),
      .o_count   (w_count),
      .o_empty_c (w_empty)
   );

   // Serialiser: one lane of the head word per cycle, lane0 first
   always_ff @(posedge CLK or negedge RESET_L) begin
      if (!RESET_L) begin
         r_d     <= '0;
         r_dk    <= 1'b1;
         r_valid <= 1'b0;
         r_lane  <= '0;
      end else if (!w_empty) begin
         r_d     <= BITS'(w_head.sym[r_lane]);
         r_dk    <= w_head.dk[r_lane];
         r_valid <= 1'b1;
         r_lane  <= r_lane + 2'd1;
      end else begin
         r_valid <= 1'b0;
      end
   end

   // Framing state register
   always_ff @(posedge CLK or negedge RESET_L) begin
      if (!RESET_L) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   // Framing next state and error detection on the word being accepted
   always_comb begin
      w_state_nxt = r_state;
      w_mid       = r_state;
      w_hit       = '0;
      w_code      = ERR_NONE;

      // lane0 may open a packet; lanes 1-3 are judged in the post-lane0 state
      if (is_start(w_in.sym[0], w_in.dk[0])) begin
         if (r_state == ST_PKT) w_hit[3] = 1'b1;
         else                   w_mid    = ST_PKT;
      end

      for (int k = 0; k < int'(LANES); k++) begin
         if (k > 0 && is_start(w_in.sym[k], w_in.dk[k]))                w_hit[1] = 1'b1;
         if (k < int'(LANES) - 1 && is_end(w_in.sym[k], w_in.dk[k]))    w_hit[2] = 1'b1;
         if (w_in.dk[k] && (((k == 0) ? r_state : w_mid) == ST_IDLE))  w_hit[4] = 1'b1;
         if (w_in.dk[k] && is_frame_code(w_in.sym[k]))                 w_hit[5] = 1'b1;
      end

      for (int c = 5; c >= 1; c--) begin
         if (w_hit[c]) w_code = 3'(c);
      end

      if (w_push) begin
         w_state_nxt = w_mid;
         if (w_mid == ST_PKT && is_end(w_in.sym[LANES-1], w_in.dk[LANES-1]))
            w_state_nxt = ST_IDLE;
      end
   end

   // One-cycle error pulse following an accepted faulty word
   always_ff @(posedge CLK or negedge RESET_L) begin
      if (!RESET_L) begin
         r_err      <= 1'b0;
         r_err_code <= ERR_NONE;
      end else begin
         r_err      <= w_push && (w_code != ERR_NONE);
         r_err_code <= w_push ? w_code : ERR_NONE;
      end
   end

   assign bus.D         = r_d;
   assign bus.DK        = r_dk;
   assign bus.VALID_OUT = r_valid;
   assign bus.IN_PKT    = (r_state == ST_PKT);
   assign bus.ERR       = r_err;
   assign bus.ERR_CODE  = r_err_code;
endmodule
